// File: rtl/decode_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue: instruction
// field positions, entry packing layout and the per-cycle queue operation.
package decode_queue_pkg;

  localparam int INSTR_W    = 32;
  localparam int REG_W      = 5;
  localparam int RD_LSB     = 7;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int OP_W       = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_W   = 3;
  localparam int FUNCT7B5   = 30;

  // Entry is packed MSB-first as {Instr, PC, PCPlus4, PredPCTarget, PCSrcPred}.
  function automatic int entry_width(input int xlen);
    return INSTR_W + 3 * xlen + 1;
  endfunction

  function automatic int tgt_lsb(input int xlen);
    return 1;
  endfunction

  function automatic int pc4_lsb(input int xlen);
    return 1 + xlen;
  endfunction

  function automatic int pc_lsb(input int xlen);
    return 1 + 2 * xlen;
  endfunction

  function automatic int instr_lsb(input int xlen);
    return 1 + 3 * xlen;
  endfunction

  typedef enum logic [2:0] {
    Q_IDLE     = 3'd0,
    Q_PUSH     = 3'd1,
    Q_POP      = 3'd2,
    Q_PUSH_POP = 3'd3,
    Q_FLUSH    = 3'd4
  } q_op_e;

endpackage

// File: rtl/decode_queue_if.sv
// Fetch/decode handshake bundle for decode_queue. The queue uses the slave
// view; the environment (fetch producer plus decode consumer) uses master.
interface decode_queue_if #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]     InstrF;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] PCPlus4F;
  logic [XLEN-1:0] PredPCTargetF;
  logic            PCSrcPredF;
  logic            ValidF;
  logic            ReadyF;
  logic            StallD;
  logic            FlushD;
  logic            ValidD;
  logic [31:0]     InstrD;
  logic [XLEN-1:0] PCD;
  logic [XLEN-1:0] PCPlus4D;
  logic [XLEN-1:0] PredPCTargetD;
  logic            PCSrcPredD;
  logic [4:0]      RdD;
  logic [4:0]      Rs1D;
  logic [4:0]      Rs2D;
  logic [6:0]      OpD;
  logic [2:0]      funct3D;
  logic            funct7b5D;
  logic [CW-1:0]   CountD;

  modport slave (
    input  InstrF, PCF, PCPlus4F, PredPCTargetF, PCSrcPredF, ValidF,
    input  StallD, FlushD,
    output ReadyF, ValidD, InstrD, PCD, PCPlus4D, PredPCTargetD, PCSrcPredD,
    output RdD, Rs1D, Rs2D, OpD, funct3D, funct7b5D, CountD
  );

  modport master (
    output InstrF, PCF, PCPlus4F, PredPCTargetF, PCSrcPredF, ValidF,
    output StallD, FlushD,
    input  ReadyF, ValidD, InstrD, PCD, PCPlus4D, PredPCTargetD, PCSrcPredD,
    input  RdD, Rs1D, Rs2D, OpD, funct3D, funct7b5D, CountD
  );

endinterface

// File: rtl/decode_queue_mem.sv
// Entry storage for decode_queue: DEPTH x W register array, one synchronous
// write port and one asynchronous read port. Contents are not reset.
module decode_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 129,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_r [DEPTH];

  // Write the incoming entry at the write pointer.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/decode_queue.sv
// Fetch-to-decode instruction queue: circular buffer with first-word-fall-
// through head outputs, pre-split instruction fields and synchronous flush.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic           clk,
  input logic           reset,
  decode_queue_if.slave q
);

  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;
  localparam int EW        = entry_width(XLEN);
  localparam int TGT_LSB   = tgt_lsb(XLEN);
  localparam int PC4_LSB   = pc4_lsb(XLEN);
  localparam int PC_LSB    = pc_lsb(XLEN);
  localparam int INSTR_LSB = instr_lsb(XLEN);

  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [CW-1:0] count_r;

  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  q_op_e         op_s;
  logic [EW-1:0] wdata_s;
  logic [EW-1:0] rdata_s;
  logic [EW-1:0] head_s;
  logic [31:0]   instr_s;

  // Full blocks a push even when a pop happens on the same edge.
  assign full_s  = (count_r == CW'(DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});
  assign push_s  = q.ValidF & ~full_s;
  assign pop_s   = ~empty_s & ~q.StallD;

  assign wdata_s = {q.InstrF, q.PCF, q.PCPlus4F, q.PredPCTargetF, q.PCSrcPredF};

  // Classify this cycle's queue operation; flush overrides everything.
  always_comb begin
    op_s = Q_IDLE;
    if (q.FlushD) begin
      op_s = Q_FLUSH;
    end else begin
      case ({push_s, pop_s})
        2'b10:   op_s = Q_PUSH;
        2'b01:   op_s = Q_POP;
        2'b11:   op_s = Q_PUSH_POP;
        default: op_s = Q_IDLE;
      endcase
    end
  end

  // Pointer and occupancy update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      case (op_s)
        Q_FLUSH: begin
          wptr_r  <= {AW{1'b0}};
          rptr_r  <= {AW{1'b0}};
          count_r <= {CW{1'b0}};
        end
        Q_PUSH: begin
          wptr_r  <= wptr_r + AW'(1);
          count_r <= count_r + CW'(1);
        end
        Q_POP: begin
          rptr_r  <= rptr_r + AW'(1);
          count_r <= count_r - CW'(1);
        end
        Q_PUSH_POP: begin
          wptr_r <= wptr_r + AW'(1);
          rptr_r <= rptr_r + AW'(1);
        end
        default: begin
          wptr_r  <= wptr_r;
          rptr_r  <= rptr_r;
          count_r <= count_r;
        end
      endcase
    end
  end

  decode_queue_mem #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_mem (
    .clk   (clk),
    .we    (push_s & ~q.FlushD),
    .waddr (wptr_r),
    .wdata (wdata_s),
    .raddr (rptr_r),
    .rdata (rdata_s)
  );

  // An empty queue presents an all-zero bubble rather than stale storage.
  always_comb begin
    if (empty_s) begin
      head_s = {EW{1'b0}};
    end else begin
      head_s = rdata_s;
    end
  end

  assign instr_s         = head_s[INSTR_LSB +: INSTR_W];

  assign q.ReadyF        = ~full_s;
  assign q.ValidD        = ~empty_s;
  assign q.CountD        = count_r;
  assign q.InstrD        = instr_s;
  assign q.PCD           = head_s[PC_LSB +: XLEN];
  assign q.PCPlus4D      = head_s[PC4_LSB +: XLEN];
  assign q.PredPCTargetD = head_s[TGT_LSB +: XLEN];
  assign q.PCSrcPredD    = head_s[0];

  assign q.RdD           = instr_s[RD_LSB +: REG_W];
  assign q.Rs1D          = instr_s[RS1_LSB +: REG_W];
  assign q.Rs2D          = instr_s[RS2_LSB +: REG_W];
  assign q.OpD           = instr_s[OP_W-1:0];
  assign q.funct3D       = instr_s[FUNCT3_LSB +: FUNCT3_W];
  assign q.funct7b5D     = instr_s[FUNCT7B5];

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
Parametrised fetch-to-decode instruction buffer that replaces the single-entry decode pipeline register. It holds up to DEPTH fetched entries, each containing the instruction, PC, PC+4, predicted target and prediction bit. It presents the oldest entry to decode with its fields pre-split. Fetch and decode are decoupled by a valid/ready handshake, so a decode stall no longer has to freeze fetch immediately.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
XLEN, 32, width of PC, PC+4 and predicted-target fields
CW, $clog2(DEPTH)+1, derived occupancy-count width; not overridable

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
InstrF  in  32  fetched instruction
PCF  in  XLEN  fetch PC
PCPlus4F  in  XLEN  fetch PC+4
PredPCTargetF  in  XLEN  branch-predictor target
PCSrcPredF  in  1  predicted-taken bit
ValidF  in  1  fetch offers an entry this cycle
ReadyF  out  1  queue can accept an entry (not full)
StallD  in  1  decode cannot consume the head entry this cycle
FlushD  in  1  discard all entries, for example on a branch mispredict
ValidD  out  1  head entry present
InstrD  out  32  head instruction
PCD, PCPlus4D, PredPCTargetD  out  XLEN each  head fields
PCSrcPredD  out  1  head prediction bit
RdD, Rs1D, Rs2D  out  5 each  InstrD[11:7], InstrD[19:15], InstrD[24:20]
OpD  out  7  InstrD[6:0]
funct3D  out  3  InstrD[14:12]
funct7b5D  out  1  InstrD[30]
CountD  out  CW  current occupancy, 0..DEPTH

Behaviour:
- Storage: circular buffer of DEPTH entries, each 32+3*XLEN+1 bits. Write and read pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Push occurs when ValidF & ReadyF. Pop occurs when ValidD & ~StallD.
- ReadyF = (CountD != DEPTH), driven combinationally from registered count. There is no push-through-when-full: when full, ReadyF=0 even if a pop happens in the same cycle.
- Output timing is first-word-fall-through from registered state: head outputs are combinational from mem[rptr].
- Latency: an entry pushed at edge N is visible at ValidD after edge N. There is no same-cycle bypass from input to output.
- Empty: ValidD=0. All D data and field outputs are forced to 0, which decodes as a bubble, matching the old cleared-register behaviour.
- Simultaneous push and pop (not full, not empty): both pointers advance and CountD is unchanged.
- Push into an empty queue while StallD=1: the entry is stored and becomes the head next cycle.
- FlushD (synchronous):
  - At the next edge, wptr=rptr=0 and CountD=0.
  - Any push or pop in the same cycle is discarded.
  - ValidD=0 the following cycle.
  - FlushD has priority over StallD and ValidF.
- Asynchronous reset:
  - wptr, rptr and CountD are cleared immediately.
  - ValidD=0, all D outputs=0, ReadyF=1.
  - Reset asserted mid-operation loses all entries; storage contents need not be cleared.
- StallD while empty has no effect.
- ValidF while full is ignored (no push); fetch must hold its entry.
- CountD invariants: never exceeds DEPTH, never underflows.

Decomposition:
- Shared package holds:
  - instruction field bit positions (RD_LSB=7, RS1_LSB=15, RS2_LSB=20, OP_W=7, FUNCT3_LSB=12, FUNCT7B5=30);
  - the entry packing order {Instr, PC, PCPlus4, PredPCTarget, PCSrcPred}.
- One natural sub-module, decode_queue_mem: DEPTH x entry-width register array with write enable, write pointer and read pointer. It has no reset on storage.
- Field extraction and output masking stay in the top level.

Test Plan:
- Reset during traffic (2 entries held), then release -> CountD=0, ValidD=0, ReadyF=1, all D outputs 0 immediately, before any clock edge.
- Push 4 entries with StallD=1, DEPTH=4, InstrF=0x00A00093/0x00208133/0x40110233/0x00312023 -> CountD=4, ReadyF=0. A 5th push is ignored. Releasing the stall pops them in order; InstrD=0x00208133 gives RdD=2, Rs1D=1, Rs2D=2, OpD=0x33, funct3D=0, funct7b5D=0.
- Push 1 entry per cycle with StallD=0 for 10 cycles -> CountD stays at 1, PCD increments by 4 each cycle, and pointers wrap past index 3 with no loss.
- Full queue with pop and push in the same cycle -> pop occurs, push is refused (ReadyF=0), and CountD becomes 3.
- FlushD=1 with CountD=3 plus simultaneous ValidF=1 -> next cycle CountD=0 and ValidD=0; the flushed-cycle entry never appears.
- Empty queue, push PCF=0x100, PredPCTargetF=0x200, PCSrcPredF=1 -> ValidD=1 one cycle later with PCD=0x100, PCPlus4D=0x104, PredPCTargetD=0x200, PCSrcPredD=1.
